compare_sequencer: RTL
======================

COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter BUS_SIZE, default 16: operand width in bits.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle; BUS_SIZE SHALL be an integer multiple of CHUNK, with NCHUNK = BUS_SIZE/CHUNK.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair present on a, b, op_signed.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 a, b  input  BUS_SIZE each  operands to compare.
REQ-008 op_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-009 out_valid  output  1  eq/lt/gt hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 eq, lt, gt  output  1 each  result flags for a==b, a<b and a>b.
REQ-012 busy  output  1  high in RUN and DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1 the block SHALL register a, b and op_signed, set chunk index idx=NCHUNK-1 and enter RUN on the next edge.
REQ-015 RUN: each cycle the block SHALL compare the registered chunk [idx*CHUNK+CHUNK-1 : idx*CHUNK] of a against the same chunk of b as unsigned values.
REQ-016 If op_signed=1 and idx=NCHUNK-1, the MSB of both chunks SHALL be inverted before the compare.
REQ-017 On an unequal chunk the block SHALL set lt or gt accordingly, clear eq and enter DONE (early exit).
REQ-018 On an equal chunk with idx>0 the block SHALL decrement idx and stay in RUN.
REQ-019 On an equal chunk with idx=0 the block SHALL set eq=1, lt=0, gt=0 and enter DONE.
REQ-020 Latency from the accept edge to out_valid=1 SHALL be (NCHUNK-k) cycles, where k is the index of the most significant differing chunk, or NCHUNK cycles when a==b (1 minimum, 4 maximum at defaults).
REQ-021 DONE: out_valid=1 and in_ready=0; eq/lt/gt SHALL stay stable until out_valid&out_ready, after which the block SHALL return to IDLE on the next edge.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL not disturb the registered operands.
REQ-023 Exactly one of eq/lt/gt SHALL be 1 whenever out_valid=1.
REQ-024 eq/lt/gt SHALL retain the last result in IDLE and RUN until overwritten when the block next enters DONE.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 An out_valid&out_ready handshake SHALL not be followed by a same-cycle accept; the earliest new accept SHALL be the cycle after the block returns to IDLE.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL enter IDLE with idx=NCHUNK-1 and internal operand registers cleared.
REQ-028 After that reset edge: in_ready=1, out_valid=0, busy=0, eq=0, lt=0, gt=0.
REQ-029 rst SHALL take priority over every other input, including in RUN or DONE; any in-flight compare SHALL be discarded with no result ever presented.

Verification
REQ-030 Unsigned equal: a=16'h1234, b=16'h1234, op_signed=0 -> out_valid after 4 cycles with eq=1, lt=0, gt=0.
REQ-031 Early exit: a=16'h8000, b=16'h7FFF, op_signed=0 -> out_valid after 1 cycle with gt=1; the same operands with op_signed=1 -> out_valid after 1 cycle with lt=1.
REQ-032 Low-chunk difference: a=16'h00A3, b=16'h00A5, op_signed=0 -> out_valid after 4 cycles with lt=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> flags stable, in_ready=0 and in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 Reset mid-RUN: assert rst during the 2nd RUN cycle of a==b -> next cycle shows IDLE, out_valid=0, all flags 0, and no result appears.
REQ-035 Back-to-back: issue 16'hFFFF vs 16'h0001 signed, then 16'h0002 vs 16'h0001 unsigned -> results lt=1, then gt=1, in order.

Source files
------------

// File: rtl/compare_sequencer.sv
// compare_sequencer: chunk-serial magnitude comparator, MSB chunk first with early exit.
// Signed compares flip the sign bit of the top chunk so an unsigned chunk compare suffices.
module compare_sequencer #(
    parameter int BUS_SIZE = 16,
    parameter int CHUNK    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                op_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                eq,
    output logic                lt,
    output logic                gt,
    output logic                busy
);
    localparam int NCHUNK = BUS_SIZE / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;
    logic [BUS_SIZE-1:0] ra, rb;
    logic rs;
    logic [IW-1:0] idx;
    logic [CHUNK-1:0] ca, cb, msb;
    logic differ;

    always_comb begin
        msb = '0;
        msb[CHUNK-1] = rs && idx == TOP;
        ca = ra[idx*CHUNK +: CHUNK] ^ msb;
        cb = rb[idx*CHUNK +: CHUNK] ^ msb;
        differ = ca != cb;
        state_n = state;
        case (state)
            IDLE: state_n = in_valid ? RUN : IDLE;
            RUN:  state_n = (differ || idx == '0) ? DONE : RUN;
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= TOP;
            ra    <= '0;
            rb    <= '0;
            rs    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                ra  <= a;
                rb  <= b;
                rs  <= op_signed;
                idx <= TOP;
            end
            if (state == RUN) begin
                if (differ) begin
                    eq <= 1'b0;
                    lt <= ca < cb;
                    gt <= ca > cb;
                end else if (idx == '0) begin
                    eq <= 1'b1;
                    lt <= 1'b0;
                    gt <= 1'b0;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end
endmodule
